// File: rtl/xava_mem_arbiter.sv
// xava_mem_arbiter: round-robin share of one OBI memory port between instr fetch, core data and VLSU.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   instr_*                       fetch request/response (read-only, 32-bit lane-selected rdata)
//   data_*, vlsu_*                full-width request/response channels
//   mem_*                         downstream OBI request/response
//   outstanding_o                 in-flight request count (FIFO occupancy)
//   spurious_o                    sticky flag: rvalid seen with nothing outstanding
module xava_mem_arbiter #(
    parameter int MEM_W           = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 instr_req_i,
    output logic                                 instr_gnt_o,
    input  logic [31:0]                          instr_addr_i,
    output logic                                 instr_rvalid_o,
    output logic [31:0]                          instr_rdata_o,
    output logic                                 instr_err_o,
    input  logic                                 data_req_i,
    output logic                                 data_gnt_o,
    input  logic [31:0]                          data_addr_i,
    input  logic                                 data_we_i,
    input  logic [MEM_W/8-1:0]                   data_be_i,
    input  logic [MEM_W-1:0]                     data_wdata_i,
    output logic                                 data_rvalid_o,
    output logic [MEM_W-1:0]                     data_rdata_o,
    output logic                                 data_err_o,
    input  logic                                 vlsu_req_i,
    output logic                                 vlsu_gnt_o,
    input  logic [31:0]                          vlsu_addr_i,
    input  logic                                 vlsu_we_i,
    input  logic [MEM_W/8-1:0]                   vlsu_be_i,
    input  logic [MEM_W-1:0]                     vlsu_wdata_i,
    output logic                                 vlsu_rvalid_o,
    output logic [MEM_W-1:0]                     vlsu_rdata_o,
    output logic                                 vlsu_err_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [31:0]                          mem_addr_o,
    output logic                                 mem_we_o,
    output logic [MEM_W/8-1:0]                   mem_be_o,
    output logic [MEM_W-1:0]                     mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [MEM_W-1:0]                     mem_rdata_i,
    input  logic                                 mem_err_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 spurious_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int OB = $clog2(MEM_W / 32);
    localparam int OW = OB > 0 ? OB : 1;

    logic [1:0]    ptr_q;
    logic [1:0]    sel;
    logic [2:0]    req_v;
    logic          any_req, full, gnt, pop;
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          spurious_q;
    logic [1:0]    src_q [MAX_OUTSTANDING];
    logic [OW-1:0] off_q [MAX_OUTSTANDING];
    logic [1:0]    head_src;
    logic [OW-1:0] head_off, push_off;

    assign req_v   = {vlsu_req_i, data_req_i, instr_req_i};
    assign any_req = |req_v;
    assign full    = count_q == CW'(MAX_OUTSTANDING);
    assign gnt     = any_req & mem_gnt_i & ~full;

    // First requester at or after the pointer in cyclic order 0 -> 1 -> 2
    assign sel = ptr_q == 2'd0 ? (req_v[0] ? 2'd0 : req_v[1] ? 2'd1 : 2'd2) :
                 ptr_q == 2'd1 ? (req_v[1] ? 2'd1 : req_v[2] ? 2'd2 : 2'd0) :
                                 (req_v[2] ? 2'd2 : req_v[0] ? 2'd0 : 2'd1);

    assign mem_req_o   = any_req & ~full;
    assign instr_gnt_o = gnt & (sel == 2'd0);
    assign data_gnt_o  = gnt & (sel == 2'd1);
    assign vlsu_gnt_o  = gnt & (sel == 2'd2);

    assign mem_addr_o  = !any_req ? '0 : sel == 2'd0 ? instr_addr_i : sel == 2'd1 ? data_addr_i : vlsu_addr_i;
    assign mem_we_o    = any_req & (sel == 2'd1 ? data_we_i : sel == 2'd2 ? vlsu_we_i : 1'b0);
    assign mem_be_o    = !any_req ? '0 : sel == 2'd0 ? '1 : sel == 2'd1 ? data_be_i : vlsu_be_i;
    assign mem_wdata_o = (!any_req || sel == 2'd0) ? '0 : sel == 2'd1 ? data_wdata_i : vlsu_wdata_i;

    // 32-bit lane index of the request inside the MEM_W word (always 0 for MEM_W=32)
    assign push_off = OW'((mem_addr_o >> 2) & 32'(MEM_W / 32 - 1));

    assign pop      = mem_rvalid_i & (count_q != '0);
    assign head_src = src_q[rd_q];
    assign head_off = pop ? off_q[rd_q] : '0;

    assign instr_rvalid_o = pop & (head_src == 2'd0);
    assign data_rvalid_o  = pop & (head_src == 2'd1);
    assign vlsu_rvalid_o  = pop & (head_src == 2'd2);
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign vlsu_err_o     = vlsu_rvalid_o & mem_err_i;
    assign instr_rdata_o  = 32'(mem_rdata_i >> {head_off, 5'd0});
    assign data_rdata_o   = mem_rdata_i;
    assign vlsu_rdata_o   = mem_rdata_i;

    assign outstanding_o = count_q;
    assign spurious_o    = spurious_q;

    always_ff @(posedge clk_i) begin
        if (gnt) begin
            src_q[wr_q] <= sel;
            off_q[wr_q] <= push_off;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= 2'd0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (gnt) begin
                wr_q  <= wr_q + 1'b1;
                ptr_q <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(gnt) - CW'(pop);
            if (mem_rvalid_i && count_q == '0) spurious_q <= 1'b1;
        end
    end
endmodule

// File: doc/xava_mem_arbiter.md
Name: xava_mem_arbiter

Overview:
- Shares one downstream OBI-style memory port between three requesters: core instruction fetch, core data, and the xava VLSU data port.
- Round-robin grant among the three requesters.
- An in-order source/offset FIFO routes each response (rvalid/rdata/err) back to the requester that issued it.
- Sits in the SoC wrapper between cv32e40x_core/xava and the single memory port.

Parameters:
MEM_W, 32, downstream data width in bits (power of two, >=32)
MAX_OUTSTANDING, 8, maximum accepted-but-unanswered requests (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_addr_i  in  32  fetch address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch word, lane-selected from mem_rdata_i
instr_err_o  out  1  fetch bus error
data_req_i / data_gnt_o / data_addr_i[32] / data_we_i / data_be_i[MEM_W/8] / data_wdata_i[MEM_W]  in/out/in/in/in/in  core data request channel
data_rvalid_o / data_rdata_o[MEM_W] / data_err_o  out  core data response channel
vlsu_req_i / vlsu_gnt_o / vlsu_addr_i[32] / vlsu_we_i / vlsu_be_i[MEM_W/8] / vlsu_wdata_i[MEM_W]  in/out/in/in/in/in  VLSU request channel
vlsu_rvalid_o / vlsu_rdata_o[MEM_W] / vlsu_err_o  out  VLSU response channel
mem_req_o / mem_gnt_i / mem_addr_o[32] / mem_we_o / mem_be_o[MEM_W/8] / mem_wdata_o[MEM_W]  out/in/out/out/out/out  downstream request
mem_rvalid_i / mem_rdata_i[MEM_W] / mem_err_i  in  downstream response
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
spurious_o  out  1  sticky: rvalid arrived with FIFO empty

Behaviour:
- Reset (async, rst_i=1):
  - RR pointer = instr (priority order instr, data, vlsu).
  - FIFO empty; outstanding_o = 0; spurious_o = 0.
  - All outputs combinationally 0 while no request is pending.
- Selection (combinational):
  - The first requester at or after the RR pointer, in cyclic order instr -> data -> vlsu, is chosen.
  - full = (outstanding == MAX_OUTSTANDING).
  - mem_req_o = any req & ~full.
  - mem_addr_o/we/be/wdata are muxed from the chosen requester. For instr: we=0, be=all ones, wdata=0.
- Grant:
  - chosen_gnt_o = chosen & mem_gnt_i & ~full. All other gnt_o = 0.
  - At most one gnt per cycle.
  - Requests are not registered; requesters hold req/addr stable until granted (OBI rule).
- RR pointer update: on a grant to requester k, the pointer moves to k+1 mod 3 on the next edge. No grant = pointer unchanged.
- FIFO push on grant. Entry = {src[1:0], addr[$clog2(MEM_W/8)-1:2]}.
- FIFO pop on mem_rvalid_i while non-empty.
  - Push and pop in the same cycle: occupancy unchanged, both entries handled.
  - Full blocks grants even if rvalid pops in that same cycle. The first regrant is the cycle after.
- Response routing (combinational, zero added latency):
  - Head src selects which of instr/data/vlsu_rvalid_o = mem_rvalid_i.
  - Only the selected err_o = mem_err_i.
  - data/vlsu_rdata_o = mem_rdata_i.
  - instr_rdata_o = mem_rdata_i[offset*32 +: 32], with offset taken from the head entry. For MEM_W=32 the offset is 0.
- Spurious response: mem_rvalid_i with FIFO empty:
  - No rvalid_o asserts.
  - spurious_o sets and stays 1 until reset.
  - Occupancy stays 0 (no underflow).
- Responses are assumed in order. Memory must answer at least one cycle after the grant; same-cycle gnt+rvalid for the same request is illegal.
- Reset mid-transaction: FIFO contents are discarded. Responses arriving after reset count as spurious.
- Write requests also occupy a FIFO entry and expect an rvalid.

Test Plan:
- Single fetch at addr 0x84, MEM_W=64, rdata=0x1111_2222_3333_4444 → instr_gnt_o in the req cycle; instr_rdata_o=0x1111_2222 on rvalid; outstanding_o 0→1→0.
- All three req held every cycle, mem_gnt_i=1, immediate 1-cycle responses → grant order instr, data, vlsu, instr, ...; each requester gets exactly 1/3 of grants over 30 cycles.
- mem_rvalid_i held 0, 9 requests from data, MAX_OUTSTANDING=8 → 8 grants; mem_req_o=0 and outstanding_o=8; one rvalid → data_rvalid_o=1; new grant the next cycle.
- Interleaved vlsu write then data read, responses with err on the first → vlsu_err_o=1 only, then data_rvalid_o with rdata passthrough; data_err_o=0.
- mem_gnt_i=0 for 5 cycles with data and vlsu requesting → no gnt_o, RR pointer unchanged; the grant goes to the same requester once mem_gnt_i=1.
- rvalid with empty FIFO → spurious_o=1 sticky, no rvalid_o; assert rst_i with 3 outstanding → outstanding_o=0 and spurious_o=0 immediately (async).
